// File: rtl/idct_block_scheduler.sv
// rtl/idct_block_scheduler.sv - ping-pong buffer scheduler around a Fast IDCT core
module idct_block_scheduler #(
  parameter int ROWS         = 8,
  parameter int CORE_TIMEOUT = 4095
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        in_we,
  output logic        in_buf,
  output logic [3:0]  in_row,
  output logic        core_start,
  output logic        core_buf,
  input  logic        core_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_buf,
  output logic [3:0]  out_row,
  output logic        out_last,
  output logic        err_timeout,
  output logic [15:0] blocks_done
);

  typedef enum logic [2:0] {FREE, LOADING, READY, COMPUTE, RESULT} buf_state_t;
  typedef enum logic {IDLE, WAIT} core_state_t;

  localparam int             TW         = (CORE_TIMEOUT < 2) ? 1 : $clog2(CORE_TIMEOUT + 1);
  localparam logic [3:0]     LAST_ROW   = 4'(ROWS - 1);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(CORE_TIMEOUT - 1);

  buf_state_t    buf_state [2];
  core_state_t   core_state;
  core_state_t   core_next;
  logic          wr_ptr;
  logic          cmp_ptr;
  logic          rd_ptr;
  logic [TW-1:0] wait_cnt;
  logic          core_finish;
  logic          core_timeout;
  logic          in_last;
  logic          out_fire;
  logic          out_fire_last;

  // Handshake decode uses registered buffer state only; everything is held quiet during reset.
  assign in_ready      = !reset && (buf_state[wr_ptr] == FREE || buf_state[wr_ptr] == LOADING);
  assign in_we         = in_valid && in_ready;
  assign in_buf        = wr_ptr;
  assign in_last       = in_we && (in_row == LAST_ROW);
  assign core_buf      = cmp_ptr;
  assign out_valid     = !reset && (buf_state[rd_ptr] == RESULT);
  assign out_buf       = rd_ptr;
  assign out_last      = out_valid && (out_row == LAST_ROW);
  assign out_fire      = out_valid && out_ready;
  assign out_fire_last = out_fire && out_last;

  // Core FSM state register.
  always_ff @(posedge clock) begin
    if (reset) core_state <= IDLE;
    else       core_state <= core_next;
  end

  // Core FSM next state: launch on a READY buffer, finish on done or timeout.
  always_comb begin
    core_next    = core_state;
    core_start   = 1'b0;
    core_finish  = 1'b0;
    core_timeout = 1'b0;
    case (core_state)
      IDLE: begin
        if (!reset && buf_state[cmp_ptr] == READY) begin
          core_start = 1'b1;
          core_next  = WAIT;
        end
      end
      WAIT: begin
        if (core_done) begin
          core_finish = 1'b1;
          core_next   = IDLE;
        end else if (wait_cnt == TIMER_LAST) begin
          core_finish  = 1'b1;
          core_timeout = 1'b1;
          core_next    = IDLE;
        end
      end
      default: core_next = IDLE;
    endcase
  end

  // Counts WAIT cycles; value k-1 during the k-th WAIT cycle.
  always_ff @(posedge clock) begin
    if (reset || core_state != WAIT || core_finish) wait_cnt <= '0;
    else                                            wait_cnt <= wait_cnt + 1'b1;
  end

  // Per-buffer lifecycle; the events in one cycle always hit buffers in distinct states.
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_state[0] <= FREE;
      buf_state[1] <= FREE;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (in_we && wr_ptr == 1'(i))          buf_state[i] <= in_last ? READY : LOADING;
        if (core_start && cmp_ptr == 1'(i))    buf_state[i] <= COMPUTE;
        if (core_finish && cmp_ptr == 1'(i))   buf_state[i] <= RESULT;
        if (out_fire_last && rd_ptr == 1'(i))  buf_state[i] <= FREE;
      end
    end
  end

  // Row counters, ring pointers, sticky timeout flag and drained-block count.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_row      <= '0;
      out_row     <= '0;
      wr_ptr      <= 1'b0;
      cmp_ptr     <= 1'b0;
      rd_ptr      <= 1'b0;
      err_timeout <= 1'b0;
      blocks_done <= '0;
    end else begin
      if (in_we) begin
        if (in_last) begin
          in_row <= '0;
          wr_ptr <= ~wr_ptr;
        end else begin
          in_row <= in_row + 4'd1;
        end
      end
      if (core_finish)  cmp_ptr     <= ~cmp_ptr;
      if (core_timeout) err_timeout <= 1'b1;
      if (out_fire) begin
        if (out_last) begin
          out_row     <= '0;
          rd_ptr      <= ~rd_ptr;
          blocks_done <= blocks_done + 16'd1;
        end else begin
          out_row <= out_row + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_idct_block_scheduler.sv
// tb/tb_idct_block_scheduler.sv - self-checking bench for idct_block_scheduler
module tb_idct_block_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        cd_man = 1'b0;
  logic        cd_model = 1'b0;
  logic        core_done;

  logic        in_ready, in_we, in_buf, core_start, core_buf, out_valid, out_buf, out_last, err_timeout;
  logic [3:0]  in_row, out_row;
  logic [15:0] blocks_done;

  logic        t_in_ready, t_in_we, t_in_buf, t_core_start, t_core_buf, t_out_valid, t_out_buf, t_out_last, t_err_timeout;
  logic [3:0]  t_in_row, t_out_row;
  logic [15:0] t_blocks_done;

  assign core_done = cd_man | cd_model;

  idct_block_scheduler dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we),
    .in_buf(in_buf), .in_row(in_row), .core_start(core_start), .core_buf(core_buf),
    .core_done(core_done), .out_valid(out_valid), .out_ready(out_ready), .out_buf(out_buf),
    .out_row(out_row), .out_last(out_last), .err_timeout(err_timeout), .blocks_done(blocks_done)
  );

  idct_block_scheduler #(.CORE_TIMEOUT(15)) dut_to (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(t_in_ready), .in_we(t_in_we),
    .in_buf(t_in_buf), .in_row(t_in_row), .core_start(t_core_start), .core_buf(t_core_buf),
    .core_done(core_done), .out_valid(t_out_valid), .out_ready(out_ready), .out_buf(t_out_buf),
    .out_row(t_out_row), .out_last(t_out_last), .err_timeout(t_err_timeout), .blocks_done(t_blocks_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        iv, cd, ordy;
    logic        in_ready, in_we, in_buf;
    logic [3:0]  in_row;
    logic        core_start, core_buf, out_valid, out_buf;
    logic [3:0]  out_row;
    logic        out_last;
    logic [15:0] blocks_done;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] hs_log[$];
  int         total = 0;
  int         passed = 0;
  int         cyc = 0;
  int         due = -1;
  int         core_lat = 0;
  bit         auto_core = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called at negedge+1: records handshakes, runs the core model, moves to the next negedge.
  task automatic advance();
    if (auto_core && core_start) due = cyc + core_lat;
    if (out_valid && out_ready) hs_log.push_back({out_buf, out_row});
    @(negedge clock);
    cyc++;
    cd_model = auto_core && (cyc == due);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cd_man = 1'b0;
    auto_core = 1'b0; due = -1; cd_model = 1'b0;
    #1; advance(); #1; advance();
    reset = 1'b0;
    hs_log.delete();
  endtask

  task automatic load_rows(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; #1; advance();
    end
    in_valid = 1'b0;
  endtask

  task automatic chk_order(input string name, input int n);
    int errs = 0;
    chk({name, "_count"}, hs_log.size(), n);
    for (int j = 0; j < hs_log.size(); j++)
      if (hs_log[j] !== {1'((j / 8) % 2), 4'(j % 8)}) errs++;
    chk({name, "_order"}, errs, 0);
  endtask

  function automatic vec_t mk(input logic iv, cd, ordy, ir, we, ib, input logic [3:0] irow,
                              input logic cs, cb, ov, ob, input logic [3:0] orow,
                              input logic ol, input logic [15:0] bd);
    vec_t v;
    v.iv = iv; v.cd = cd; v.ordy = ordy; v.in_ready = ir; v.in_we = we; v.in_buf = ib;
    v.in_row = irow; v.core_start = cs; v.core_buf = cb; v.out_valid = ov; v.out_buf = ob;
    v.out_row = orow; v.out_last = ol; v.blocks_done = bd;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, stall, held;
    logic [31:0] act, exp;

    // Single block: 8 rows, core_done 20 cycles after core_start, drain 8 rows.
    for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 0, 0, 1, 1, 0, 4'(i), 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int c = 9; c <= 28; c++) vecs.push_back(mk(0, (c == 28), 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 4'(i), (i == 7), 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));

    @(negedge clock);
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) begin #1; advance(); end
    #1;
    chk("reset_hold_outputs", {core_start, out_valid, out_last, in_we}, 4'b0000);
    advance();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cd_man = 1'b1;
    #1;
    chk("reset_state", {in_ready, in_we, in_buf, in_row, core_start, out_valid, out_buf, out_row,
                        out_last, err_timeout, blocks_done}, {1'b1, 31'b0});
    advance();
    cd_man = 1'b0;
    #1;
    chk("done_after_reset_ignored", {core_start, out_valid, in_ready, blocks_done}, {3'b001, 16'd0});
    advance();

    foreach (vecs[idx]) begin
      in_valid = vecs[idx].iv; cd_man = vecs[idx].cd; out_ready = vecs[idx].ordy;
      #1;
      act = {in_ready, in_we, in_buf, in_row, core_start, vecs[idx].core_start ? core_buf : 1'b0,
             out_valid, vecs[idx].out_valid ? out_buf : 1'b0, vecs[idx].out_valid ? out_row : 4'd0,
             out_last, blocks_done};
      exp = {vecs[idx].in_ready, vecs[idx].in_we, vecs[idx].in_buf, vecs[idx].in_row,
             vecs[idx].core_start, vecs[idx].core_buf, vecs[idx].out_valid, vecs[idx].out_buf,
             vecs[idx].out_row, vecs[idx].out_last, vecs[idx].blocks_done};
      chk($sformatf("single_vec%0d", idx), act, exp);
      advance();
    end
    cd_man = 1'b0; out_ready = 1'b0;

    // Back-to-back blocks, core latency 40; third block stalls until buffer 0 drains.
    do_reset();
    auto_core = 1'b1; core_lat = 40;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; #1;
      chk($sformatf("b2b_row%0d", i), {in_ready, in_we, in_buf, in_row}, {2'b11, 1'(i / 8), 4'(i % 8)});
      advance();
    end
    in_valid = 1'b1; out_ready = 1'b1; stall = 0;
    #1;
    while (!in_ready && stall < 200) begin stall++; advance(); #1; end
    chk("b2b_stall_cycles", stall, 41);
    advance();
    for (int i = 1; i < 8; i++) begin #1; advance(); end
    in_valid = 1'b0; n = 0;
    #1;
    while (blocks_done != 16'd3 && n < 400) begin advance(); #1; n++; end
    chk("b2b_blocks_done", blocks_done, 3);
    chk_order("b2b", 24);
    advance();

    // Backpressure: out_ready low for 10 cycles while row 3 is offered.
    do_reset();
    auto_core = 1'b1; core_lat = 5;
    load_rows(8);
    out_ready = 1'b1; n = 0;
    #1;
    while (!(out_valid && out_row == 4'd3) && n < 100) begin advance(); #1; n++; end
    chk("bp_reach_row3", {out_valid, out_row}, {1'b1, 4'd3});
    held = 0;
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'b0;
      if (out_valid && out_row == 4'd3 && out_buf == 1'b0) held++;
      advance(); #1;
    end
    chk("bp_held", held, 10);
    out_ready = 1'b1; n = 0;
    while (blocks_done != 16'd1 && n < 100) begin advance(); #1; n++; end
    chk("bp_blocks_done", blocks_done, 1);
    chk_order("bp", 8);
    advance();

    // Timeout on the CORE_TIMEOUT=15 instance, then a normal block still completes.
    do_reset();
    load_rows(8);
    n = 0;
    #1;
    while (!t_core_start && n < 20) begin advance(); #1; n++; end
    chk("to_core_start", t_core_start, 1);
    k = 0;
    do begin advance(); #1; k++; end while (!t_err_timeout && k < 100);
    chk("to_err_cycle", k, 16);
    chk("to_result", {t_out_valid, t_out_buf}, 2'b10);
    out_ready = 1'b1; n = 0;
    while (t_blocks_done != 16'd1 && n < 50) begin advance(); #1; n++; end
    chk("to_drain", {t_blocks_done, t_err_timeout}, {16'd1, 1'b1});
    out_ready = 1'b0;
    chk("to_next_ready", {t_in_ready, t_in_buf}, 2'b11);
    advance();
    load_rows(8);
    n = 0;
    #1;
    while (!t_core_start && n < 20) begin advance(); #1; n++; end
    advance(); #1; advance();
    cd_man = 1'b1; #1; advance();
    cd_man = 1'b0; out_ready = 1'b1; n = 0;
    #1;
    while (t_blocks_done != 16'd2 && n < 50) begin advance(); #1; n++; end
    chk("to_next_block", {t_blocks_done, t_err_timeout}, {16'd2, 1'b1});
    advance();

    // Reset during block 2 compute; stale core_done ignored; fresh block completes.
    do_reset();
    auto_core = 1'b1; core_lat = 40;
    load_rows(16);
    out_ready = 1'b1; n = 0;
    #1;
    while (!(core_start && core_buf) && n < 200) begin advance(); #1; n++; end
    chk("rm_block2_start", {core_start, core_buf}, 2'b11);
    repeat (5) begin advance(); #1; end
    reset = 1'b1; auto_core = 1'b0; due = -1; cd_model = 1'b0;
    advance(); #1;
    chk("rm_in_reset", {core_start, out_valid, out_last, in_we}, 4'b0000);
    advance();
    reset = 1'b0; cd_man = 1'b1;
    #1;
    chk("rm_after_reset", {in_ready, in_we, core_start, out_valid, out_last, err_timeout, in_row,
                           out_row, blocks_done}, {6'b100000, 4'd0, 4'd0, 16'd0});
    advance();
    cd_man = 1'b0;
    #1;
    chk("rm_stale_done", {core_start, out_valid, blocks_done}, {2'b00, 16'd0});
    advance();
    hs_log.delete();
    auto_core = 1'b1; core_lat = 20;
    load_rows(8);
    n = 0;
    #1;
    while (blocks_done != 16'd1 && n < 100) begin advance(); #1; n++; end
    chk("rm_new_block", blocks_done, 1);
    chk_order("rm", 8);
    advance();

    // Coincident events: last row into buf 1 with core_done for buf 0,
    // then out_last of buf 0 with core_done for buf 1.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; cd_man = (i == 15);
      #1;
      if (i == 8) chk("sim_start0", {core_start, core_buf}, 2'b10);
      if (i == 15) chk("sim_row7_buf1", {in_we, in_buf, in_row, out_valid}, {2'b11, 4'd7, 1'b0});
      advance();
    end
    in_valid = 1'b0; cd_man = 1'b0;
    #1;
    chk("sim_after_first", {out_valid, out_buf, out_row, in_ready, core_start, core_buf, in_row},
        {2'b10, 4'd0, 3'b011, 4'd0});
    out_ready = 1'b1;
    advance();
    for (int r = 1; r < 8; r++) begin
      cd_man = (r == 7);
      #1;
      if (r == 7) chk("sim_last_and_done", {out_last, out_row}, {1'b1, 4'd7});
      advance();
    end
    cd_man = 1'b0; out_ready = 1'b0;
    #1;
    chk("sim_after_second", {out_valid, out_buf, out_row, blocks_done, in_ready, in_buf, core_start},
        {2'b11, 4'd0, 16'd1, 3'b100});
    advance();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
